mcuspi_frame_dec: RTL and testbench
===================================

# mcuspi_frame_dec

Parametrised decoder for the byte stream the MCU sends over SPI. It sits after the SPI byte receiver in `syn_m_top`, in the `clk_sys` domain. It locks onto a two-byte sync header and indexes each frame of `FRAME_LEN` bytes. It extracts a big-endian UTC-seconds field of configurable width and position, and publishes that field atomically once the frame ends. A watchdog drops partial frames when the link goes quiet.

## Interface
Parameters:
- `FRAME_LEN`, 18: total bytes per frame, including the header and the tail byte; must be at least 4.
- `UTC_OFS`, 8: byte index of the UTC MSB; must be at least 2.
- `UTC_BYTES`, 4: UTC field width in bytes; `UTC_OFS + UTC_BYTES` must be at most `FRAME_LEN - 1`.
- `SYNC0`, 8'hEB: value of header byte 0.
- `SYNC1`, 8'h90: value of header byte 1.
- `WD_CYCLES`, 80_000_000: number of idle `clk_sys` cycles before the watchdog aborts.

Ports:
- `clk_sys` input 1: system clock. This is the single clock of the block.
- `rst_n` input 1: asynchronous, active-low reset.
- `spi_data` input 8: received byte; valid only while `spi_vld` is high.
- `spi_vld` input 1: one-cycle strobe per byte; may be asserted back-to-back.
- `utc_sec_gps` output `8*UTC_BYTES`: last committed UTC value.
- `utc_upd` output 1: one-cycle pulse, asserted on the same edge that `utc_sec_gps` updates.
- `frame_err` output 1: one-cycle pulse on a checksum mismatch.
- `sync_lock` output 1: high while the decoder is frame-locked.
- `err_cnt` output 8: saturating error counter.

## Operation
- States: `HUNT`, `SYNC`, `BODY`.
- **HUNT**
  - A byte equal to `SYNC0` moves to `SYNC`.
  - Any other byte is ignored.
- **SYNC**
  - A byte equal to `SYNC1` moves to `BODY` and sets `idx = 2`.
  - A byte equal to `SYNC0` stays in `SYNC`.
  - Any other byte returns to `HUNT`.
- **BODY**
  - Each byte increments `idx` (width `$clog2(FRAME_LEN)`).
  - If the byte index is in `UTC_OFS .. UTC_OFS+UTC_BYTES-1`, the byte is written into shadow `utc_buf`, MSB first. Byte `UTC_OFS` lands in the top 8 bits.
  - Byte `FRAME_LEN-1` is the tail byte. Receiving it ends the frame and returns to `HUNT`; the `idx` counter never wraps.
- **Commit at end of frame:** `utc_sec_gps <= utc_buf`, `utc_upd = 1`, `sync_lock = 1`.
  - Subject to the checksum check in Configuration.
  - An aborted or rejected frame never changes `utc_sec_gps`; the shadow buffer guarantees this.
- **Watchdog**
  - The counter (width `$clog2(WD_CYCLES+1)`) clears on every `spi_vld` and otherwise increments.
  - When the count equals `WD_CYCLES` and `spi_vld` is low, the block does all of the following:
    - forces `HUNT`;
    - sets `sync_lock = 0`;
    - increments `err_cnt`, but only if the state was `SYNC` or `BODY`;
    - then holds the count at `WD_CYCLES`, so the watchdog fires exactly once per idle period.
  - When `spi_vld` and watchdog expiry occur in the same cycle, `spi_vld` wins: the byte is processed and the counter clears.
- **err_cnt:** increments on a checksum error or a mid-frame watchdog abort, and saturates at 8'hFF.
- **Reset mid-frame:** all state returns to its reset value and the partial frame is discarded.

## Timing
- Reset values:
  - `utc_sec_gps = 0`
  - `utc_upd = 0`
  - `frame_err = 0`
  - `sync_lock = 0`
  - `err_cnt = 0`
  - state = `HUNT`
  - watchdog count = 0
- All outputs are registered.
- Commit latency: `utc_upd` and the new `utc_sec_gps` appear at the first `clk_sys` edge after the cycle in which the tail byte's `spi_vld` is high. `utc_sec_gps` then holds until the next commit.
- `frame_err` has the same one-cycle latency as `utc_upd`.
- `utc_upd` and `frame_err` are mutually exclusive.
- A new `SYNC0` is accepted in the cycle immediately after the tail byte, so back-to-back frames lose no bytes.

## Configuration
- Macro: `MCUSPI_CHKSUM_EN`.
- **Defined:**
  - A running XOR is kept over bytes `0 .. FRAME_LEN-2`. It is seeded with `SYNC0^SYNC1` on entry to `BODY`.
  - At the tail byte, if the XOR equals the tail byte, the frame commits.
  - Otherwise the frame is not committed: `frame_err` pulses, `err_cnt` increments and `sync_lock` clears.
- **Undefined:**
  - The tail byte is not checked and every complete frame commits.
  - `frame_err` is tied to 0.
  - `err_cnt` counts watchdog aborts only.

## Test plan
All scenarios use default parameters.
1. Reset, then one valid frame: EB 90, bytes 2–7 = 00, bytes 8–11 = 12 34 56 78, bytes 12–16 = 00, correct XOR tail → `utc_upd` pulses once, `utc_sec_gps = 32'h12345678`, `sync_lock = 1`.
2. Leading junk and a false header: 55 EB EB 90 … followed by a valid frame → the decoder locks on the second EB and decodes correctly; no `frame_err`.
3. `MCUSPI_CHKSUM_EN` defined, tail byte corrupted (XOR with 01) → `frame_err` pulses, `utc_sec_gps` is unchanged, `err_cnt = 1`, `sync_lock = 0`.
4. Stop the stream after 10 bytes; use `WD_CYCLES = 100` to shorten the run → after 100 idle cycles the state is `HUNT` and `err_cnt` increments once. A following valid frame commits normally.
5. Two frames back-to-back with continuous `spi_vld`, UTC values 1 and 2 → two `utc_upd` pulses, each one cycle after its tail byte. Outputs read 1, then 2.
6. Apply `rst_n = 0` during byte 10 of a frame, then release reset and send a full valid frame → all outputs read 0 during reset, and the new frame decodes with no stale data.

Source files
------------

// File: rtl/mcuspi_frame_dec.sv
// MCU SPI frame decoder: hunts a two-byte sync header, indexes FRAME_LEN-byte frames, extracts a big-endian UTC field.
// Latency: utc_upd/frame_err and the committed UTC value appear one clk_sys edge after the tail byte's strobe.
// Backpressure: none; every spi_vld strobe is consumed, back-to-back. Optional tail checksum: define MCUSPI_CHKSUM_EN.
module mcuspi_frame_dec #(
    parameter int unsigned FRAME_LEN = 18,
    parameter int unsigned UTC_OFS   = 8,
    parameter int unsigned UTC_BYTES = 4,
    parameter logic [7:0]  SYNC0     = 8'hEB,
    parameter logic [7:0]  SYNC1     = 8'h90,
    parameter int unsigned WD_CYCLES = 80_000_000
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic [7:0]               spi_data,
    input  logic                     spi_vld,
    output logic [8*UTC_BYTES-1:0]   utc_sec_gps,
    output logic                     utc_upd,
    output logic                     frame_err,
    output logic                     sync_lock,
    output logic [7:0]               err_cnt
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned WD_W  = $clog2(WD_CYCLES + 1);
    localparam int unsigned UTC_W = 8 * UTC_BYTES;

    localparam logic [IDX_W-1:0] IDX_FIRST_BODY = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_TAIL       = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_UTC_LO     = IDX_W'(UTC_OFS);
    localparam logic [IDX_W-1:0] IDX_UTC_HI     = IDX_W'(UTC_OFS + UTC_BYTES);
    localparam logic [WD_W-1:0]  WD_MAX         = WD_W'(WD_CYCLES);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [UTC_W-1:0]    utc_buf_q;
    logic [UTC_W-1:0]    utc_sec_q;
    logic                utc_upd_q;
    logic                sync_lock_q;
    logic [7:0]          err_cnt_q;
    logic [WD_W-1:0]     wd_q;
    logic                wd_fired_q;

    logic                in_utc;
    logic                is_tail;
    logic                wd_fire;
    logic                chk_ok;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_utc  = (idx_q >= IDX_UTC_LO) && (idx_q < IDX_UTC_HI);
    assign is_tail = (idx_q == IDX_TAIL);
    // The watchdog acts once per idle period; a byte in the same cycle wins.
    assign wd_fire = (wd_q == WD_MAX) && !spi_vld && !wd_fired_q;

`ifdef MCUSPI_CHKSUM_EN
    logic [7:0] chk_q;
    logic       frame_err_q;

    assign chk_ok    = (chk_q == spi_data);
    assign frame_err = frame_err_q;

    // Running XOR over header and body; compared against the tail byte.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            chk_q       <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (spi_vld) begin
                if (state_q == SYNC && spi_data == SYNC1) begin
                    chk_q <= SYNC0 ^ SYNC1;
                end else if (state_q == BODY) begin
                    if (is_tail) begin
                        frame_err_q <= !chk_ok;
                    end else begin
                        chk_q <= chk_q ^ spi_data;
                    end
                end
            end
        end
    end
`else
    assign chk_ok    = 1'b1;
    assign frame_err = 1'b0;
`endif

    // Idle watchdog: clears on every byte, saturates at WD_CYCLES.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wd_q       <= '0;
            wd_fired_q <= 1'b0;
        end else if (spi_vld) begin
            wd_q       <= '0;
            wd_fired_q <= 1'b0;
        end else begin
            if (wd_q != WD_MAX) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_fire) begin
                wd_fired_q <= 1'b1;
            end
        end
    end

    // Frame FSM with registered outputs; UTC is staged in a shadow buffer and committed at the tail.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            utc_buf_q   <= '0;
            utc_sec_q   <= '0;
            utc_upd_q   <= 1'b0;
            sync_lock_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            utc_upd_q <= 1'b0;
            if (spi_vld) begin
                unique case (state_q)
                    HUNT: begin
                        if (spi_data == SYNC0) begin
                            state_q <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (spi_data == SYNC1) begin
                            state_q <= BODY;
                            idx_q   <= IDX_FIRST_BODY;
                        end else if (spi_data != SYNC0) begin
                            state_q <= HUNT;
                        end
                    end
                    BODY: begin
                        if (is_tail) begin
                            state_q <= HUNT;
                            if (chk_ok) begin
                                utc_sec_q   <= utc_buf_q;
                                utc_upd_q   <= 1'b1;
                                sync_lock_q <= 1'b1;
                            end else begin
                                sync_lock_q <= 1'b0;
                                err_cnt_q   <= sat_inc(err_cnt_q);
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (in_utc) begin
                                // UTC bytes arrive MSB first, so shifting left leaves byte UTC_OFS on top.
                                utc_buf_q <= (utc_buf_q << 8) | UTC_W'(spi_data);
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (wd_fire) begin
                state_q     <= HUNT;
                sync_lock_q <= 1'b0;
                if (state_q != HUNT) begin
                    err_cnt_q <= sat_inc(err_cnt_q);
                end
            end
        end
    end

    assign utc_sec_gps = utc_sec_q;
    assign utc_upd     = utc_upd_q;
    assign sync_lock   = sync_lock_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mcuspi_frame_dec.sv
// Directed bench for mcuspi_frame_dec with a commit scoreboard (value and cycle of each utc_upd).
// Watchdog shortened to 100 cycles; checksum expectations follow MCUSPI_CHKSUM_EN.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_mcuspi_frame_dec;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [7:0]  spi_data;
    logic        spi_vld;
    logic [31:0] utc_sec_gps;
    logic        utc_upd;
    logic        frame_err;
    logic        sync_lock;
    logic [7:0]  err_cnt;

    always #5 clk_sys = ~clk_sys;

    mcuspi_frame_dec #(
        .FRAME_LEN (18),
        .UTC_OFS   (8),
        .UTC_BYTES (4),
        .SYNC0     (8'hEB),
        .SYNC1     (8'h90),
        .WD_CYCLES (100)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .spi_data    (spi_data),
        .spi_vld     (spi_vld),
        .utc_sec_gps (utc_sec_gps),
        .utc_upd     (utc_upd),
        .frame_err   (frame_err),
        .sync_lock   (sync_lock),
        .err_cnt     (err_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int fe_cnt = 0;

    typedef struct packed {
        logic [31:0] utc;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each utc_upd pops the expected value and the cycle it must appear in.
    always @(negedge clk_sys) begin : monitor
        exp_t e;
        if (utc_upd === 1'b1) begin
            upd_cnt++;
            check("upd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("upd_value", utc_sec_gps, e.utc);
                check("upd_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (utc_upd === 1'b1 || frame_err === 1'b1)
            check("upd_fe_exclusive", {31'b0, utc_upd & frame_err}, 32'd0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        spi_data = b;
        spi_vld  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            spi_vld  = 1'b0;
            spi_data = 8'h00;
        end
    endtask

    // Sends the first nbytes of a frame carrying utc; pushes a commit expectation if asked.
    task automatic send_frame(input logic [31:0] utc, input bit corrupt, input int nbytes, input bit commit);
        logic [7:0] fb [18];
        logic [7:0] x;
        for (int i = 0; i < 18; i++) fb[i] = 8'h00;
        fb[0] = 8'hEB;
        fb[1] = 8'h90;
        fb[8]  = utc[31:24];
        fb[9]  = utc[23:16];
        fb[10] = utc[15:8];
        fb[11] = utc[7:0];
        x = 8'h00;
        for (int i = 0; i < 17; i++) x = x ^ fb[i];
        fb[17] = corrupt ? (x ^ 8'h01) : x;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(fb[i]);
            if (i == 17 && commit) exp_q.push_back('{utc: utc, cyc: cyc + 1});
        end
    endtask

    int exp_upd;
    int exp_err;
    int c0;
    int w;
    logic [7:0] e0;

    initial begin
        rst_n = 1'b0;
        spi_vld = 1'b0;
        spi_data = 8'h00;
        exp_upd = 0;
        exp_err = 0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_utc", utc_sec_gps, 32'h0);
        check("rst_upd", {31'b0, utc_upd}, 32'd0);
        check("rst_fe", {31'b0, frame_err}, 32'd0);
        check("rst_lock", {31'b0, sync_lock}, 32'd0);
        check("rst_err", {24'b0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: one valid frame
        send_frame(32'h12345678, 1'b0, 18, 1'b1);
        exp_upd++;
        idle(3);
        check("t1_upd_cnt", 32'(upd_cnt), 32'(exp_upd));
        check("t1_utc", utc_sec_gps, 32'h12345678);
        check("t1_lock", {31'b0, sync_lock}, 32'd1);
        check("t1_fe_cnt", 32'(fe_cnt), 32'd0);

        // 2: junk and a false header before a valid frame
        send_byte(8'h55);
        send_byte(8'hEB);
        send_frame(32'hA5A50001, 1'b0, 18, 1'b1);
        exp_upd++;
        idle(3);
        check("t2_upd_cnt", 32'(upd_cnt), 32'(exp_upd));
        check("t2_utc", utc_sec_gps, 32'hA5A50001);
        check("t2_fe_cnt", 32'(fe_cnt), 32'd0);
        check("t2_err", {24'b0, err_cnt}, 32'(exp_err));

        // 3: corrupted tail byte
`ifdef MCUSPI_CHKSUM_EN
        send_frame(32'hDEADBEEF, 1'b1, 18, 1'b0);
        exp_err++;
        idle(3);
        check("t3_fe_cnt", 32'(fe_cnt), 32'd1);
        check("t3_utc_kept", utc_sec_gps, 32'hA5A50001);
        check("t3_lock", {31'b0, sync_lock}, 32'd0);
`else
        send_frame(32'hDEADBEEF, 1'b1, 18, 1'b1);
        exp_upd++;
        idle(3);
        check("t3_fe_cnt", 32'(fe_cnt), 32'd0);
        check("t3_utc", utc_sec_gps, 32'hDEADBEEF);
        check("t3_lock", {31'b0, sync_lock}, 32'd1);
`endif
        check("t3_err", {24'b0, err_cnt}, 32'(exp_err));
        check("t3_upd_cnt", 32'(upd_cnt), 32'(exp_upd));

        // 4: stream stops after 10 bytes; watchdog aborts once
        send_frame(32'h11111111, 1'b0, 10, 1'b0);
        c0 = cyc;
        e0 = err_cnt;
        w = 0;
        while (err_cnt == e0 && w < 300) begin
            @(negedge clk_sys);
            spi_vld = 1'b0;
            w++;
        end
        exp_err++;
        check("t4_wd_err", {24'b0, err_cnt}, 32'(exp_err));
        check("t4_wd_timing", 32'((cyc - c0) >= 100 && (cyc - c0) <= 103), 32'd1);
        check("t4_lock", {31'b0, sync_lock}, 32'd0);
        idle(150);
        check("t4_wd_once", {24'b0, err_cnt}, 32'(exp_err));
        send_frame(32'h0BADCAFE, 1'b0, 18, 1'b1);
        exp_upd++;
        idle(3);
        check("t4_utc", utc_sec_gps, 32'h0BADCAFE);
        check("t4_upd_cnt", 32'(upd_cnt), 32'(exp_upd));
        check("t4_lock_after", {31'b0, sync_lock}, 32'd1);

        // 5: back-to-back frames with continuous strobes
        send_frame(32'h00000001, 1'b0, 18, 1'b1);
        send_frame(32'h00000002, 1'b0, 18, 1'b1);
        exp_upd += 2;
        idle(3);
        check("t5_upd_cnt", 32'(upd_cnt), 32'(exp_upd));
        check("t5_utc", utc_sec_gps, 32'h00000002);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of a frame
        send_frame(32'h77777777, 1'b0, 10, 1'b0);
        @(negedge clk_sys);
        rst_n = 1'b0;
        spi_vld = 1'b0;
        #1;
        check("t6_rst_utc", utc_sec_gps, 32'h0);
        check("t6_rst_lock", {31'b0, sync_lock}, 32'd0);
        check("t6_rst_err", {24'b0, err_cnt}, 32'd0);
        check("t6_rst_upd", {31'b0, utc_upd | frame_err}, 32'd0);
        exp_err = 0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        send_frame(32'h00C0FFEE, 1'b0, 18, 1'b1);
        exp_upd++;
        idle(3);
        check("t6_utc", utc_sec_gps, 32'h00C0FFEE);
        check("t6_upd_cnt", 32'(upd_cnt), 32'(exp_upd));
        check("t6_lock", {31'b0, sync_lock}, 32'd1);
        check("t6_err", {24'b0, err_cnt}, 32'(exp_err));
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
